// File: rtl/braun_mult8_seq.sv
// Sequential 8x8 unsigned multiplier built from one 4x4 array reused over four passes.
// Partial products are shifted and accumulated into a 16-bit result.

module braun_multiplier (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    logic [7:0] sum_s;

    // Row-by-row array: each multiplier bit adds its AND row at its weight
    always_comb begin
        sum_s = {4'b0000, a & {4{b[0]}}};
        for (int i = 1; i < 4; i++) begin
            sum_s = sum_s + ({4'b0000, a & {4{b[i]}}} << i);
        end
        p = sum_s;
    end

endmodule

module braun_mult8_seq #(
    parameter bit REG_PP = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] p,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      state_r, state_n;
    logic [7:0]  a_r, b_r;
    logic [15:0] acc_r, acc_n;
    logic [1:0]  pass_r, pass_n;
    logic [7:0]  pp_r;
    logic        in_ready_r, out_valid_r, busy_r;

    logic [3:0]  op_a_s, op_b_s;
    logic [7:0]  pp_s, pp_sel_s;
    logic [15:0] shifted_s;
    logic        load_s, pp_load_s;

    // Cross terms (aL*bH, aH*bL) sit at weight 4, the high*high term at weight 8
    function automatic logic [3:0] pass_shift(input logic [1:0] pass);
        return {1'b0, pass[0] & pass[1], pass[0] ^ pass[1], 1'b0} << 1;
    endfunction

    assign op_a_s    = pass_r[1] ? a_r[7:4] : a_r[3:0];
    assign op_b_s    = pass_r[0] ? b_r[7:4] : b_r[3:0];
    assign pp_sel_s  = REG_PP ? pp_r : pp_s;
    assign shifted_s = {8'h00, pp_sel_s} << pass_shift(pass_r);

    braun_multiplier u_array (
        .a (op_a_s),
        .b (op_b_s),
        .p (pp_s)
    );

    // Next-state, accumulate and pass sequencing
    always_comb begin
        state_n   = state_r;
        acc_n     = acc_r;
        pass_n    = pass_r;
        load_s    = 1'b0;
        pp_load_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid && in_ready_r) begin
                    load_s  = 1'b1;
                    acc_n   = 16'h0000;
                    pass_n  = 2'd0;
                    state_n = ST_MUL;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_MUL, ST_WAIT: begin
                if (REG_PP && (state_r == ST_MUL)) begin
                    pp_load_s = 1'b1;
                    state_n   = ST_WAIT;
                end else begin
                    acc_n = acc_r + shifted_s;
                    if (pass_r == 2'd3) begin
                        state_n = ST_DONE;
                    end else begin
                        pass_n  = pass_r + 2'd1;
                        state_n = ST_MUL;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_DONE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            a_r         <= 8'h00;
            b_r         <= 8'h00;
            acc_r       <= 16'h0000;
            pass_r      <= 2'd0;
            pp_r        <= 8'h00;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_n;
            acc_r       <= acc_n;
            pass_r      <= pass_n;
            in_ready_r  <= (state_n == ST_IDLE);
            out_valid_r <= (state_n == ST_DONE);
            busy_r      <= (state_n != ST_IDLE);
            if (load_s) begin
                a_r <= a;
                b_r <= b;
            end else begin
                a_r <= a_r;
                b_r <= b_r;
            end
            if (pp_load_s) begin
                pp_r <= pp_s;
            end else begin
                pp_r <= pp_r;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign p         = acc_r;

endmodule

// File: tb/tb_braun_mult8_seq.sv
// Directed bench for braun_mult8_seq: one instance per REG_PP setting, expected
// products queued at accept and compared at output.

module tb_braun_mult8_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [7:0]  a         [2];
    logic [7:0]  b         [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [15:0] p         [2];
    logic        busy      [2];

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    braun_mult8_seq #(.REG_PP(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a[0]), .b(b[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .p(p[0]), .busy(busy[0])
    );

    braun_mult8_seq #(.REG_PP(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a[1]), .b(b[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .p(p[1]), .busy(busy[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transaction on instance s; bp = cycles of out_ready=0 after out_valid rises
    task automatic run_op(input int s, input logic [7:0] av, input logic [7:0] bv,
                          input int lat, input int bp, input bit hold_valid,
                          output int acc_cyc);
        int n;
        logic [15:0] e;
        a[s] = av;
        b[s] = bv;
        in_valid[s] = 1'b1;
        n = 0;
        while (!in_ready[s] && n < 40) begin
            step();
            n++;
        end
        check("accept_timeout", 32'(n < 40), 32'd1);
        exp_q.push_back({8'h00, av} * {8'h00, bv});
        step();
        acc_cyc = cyc;
        if (hold_valid) begin
            a[s] = 8'hFF;
            b[s] = 8'hFF;
        end else begin
            in_valid[s] = 1'b0;
        end
        if (bp > 0) out_ready[s] = 1'b0;
        n = 0;
        while (!out_valid[s] && n < 40) begin
            check("in_ready_while_busy", 32'(in_ready[s]), 32'd0);
            check("busy_while_mul", 32'(busy[s]), 32'd1);
            step();
            n++;
        end
        check("latency", n, lat);
        e = exp_q.pop_front();
        check("product", 32'(p[s]), 32'(e));
        check("no_ready_with_valid", 32'(in_ready[s]), 32'd0);
        for (int i = 0; i < bp; i++) begin
            step();
            check("bp_hold_p", 32'(p[s]), 32'(e));
            check("bp_out_valid", 32'(out_valid[s]), 32'd1);
            check("bp_in_ready", 32'(in_ready[s]), 32'd0);
            check("bp_busy", 32'(busy[s]), 32'd1);
        end
        out_ready[s] = 1'b1;
        step();
        check("handshake_out_valid", 32'(out_valid[s]), 32'd0);
        check("handshake_in_ready", 32'(in_ready[s]), 32'd1);
        check("handshake_busy", 32'(busy[s]), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: observed cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t1, t2, n;
        logic [7:0] ra, rb;
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            in_valid[s]  = 1'b0;
            a[s]         = 8'h00;
            b[s]         = 8'h00;
            out_ready[s] = 1'b1;
        end
        #22;
        check("rst_in_ready", 32'(in_ready[0]), 32'd0);
        check("rst_out_valid", 32'(out_valid[0]), 32'd0);
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_p", 32'(p[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("in_ready_after_reset", 32'(in_ready[0]), 32'd1);

        // Back-to-back with in_valid and out_ready held high
        run_op(0, 8'h12, 8'h34, 4, 0, 1'b1, t1);
        run_op(0, 8'hFF, 8'hFF, 4, 0, 1'b0, t2);
        check("b2b_spacing", t2 - t1, 6);

        // Backpressure
        run_op(0, 8'hA5, 8'h5A, 4, 10, 1'b0, t1);

        // Zero and identity
        run_op(0, 8'h00, 8'hC3, 4, 0, 1'b0, t1);
        run_op(0, 8'h01, 8'hC3, 4, 0, 1'b0, t1);
        run_op(0, 8'hC3, 8'h10, 4, 0, 1'b0, t1);

        // Operands changing while busy are ignored; next accept only after handshake
        run_op(0, 8'h0F, 8'hF0, 4, 0, 1'b1, t1);
        run_op(0, 8'hFF, 8'hFF, 4, 0, 1'b0, t2);
        check("busy_ignore_spacing", t2 - t1, 6);

        // Asynchronous reset between E2 and E3
        a[0] = 8'h77;
        b[0] = 8'h99;
        in_valid[0] = 1'b1;
        n = 0;
        while (!in_ready[0] && n < 40) begin
            step();
            n++;
        end
        step();
        in_valid[0] = 1'b0;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid[0]), 32'd0);
        check("midrst_busy", 32'(busy[0]), 32'd0);
        check("midrst_in_ready", 32'(in_ready[0]), 32'd0);
        check("midrst_p", 32'(p[0]), 32'd0);
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("midrst_in_ready_rise", 32'(in_ready[0]), 32'd1);
        for (int i = 0; i < 6; i++) begin
            check("midrst_no_out_valid", 32'(out_valid[0]), 32'd0);
            step();
        end
        run_op(0, 8'h77, 8'h99, 4, 0, 1'b0, t1);

        // REG_PP=1: corners then a random sweep
        run_op(1, 8'h00, 8'h00, 8, 0, 1'b0, t1);
        run_op(1, 8'hFF, 8'hFF, 8, 0, 1'b0, t1);
        run_op(1, 8'hFF, 8'h01, 8, 0, 1'b0, t1);
        run_op(1, 8'h80, 8'h80, 8, 3, 1'b0, t1);
        for (int i = 0; i < 300; i++) begin
            ra = 8'($urandom_range(255, 0));
            rb = 8'($urandom_range(255, 0));
            run_op(1, ra, rb, 8, 0, 1'b0, t1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
